// File: rtl/ysyx_22040237_core_pkg.sv
// Shared state encoding and trap-cause codes for the multi-cycle core sequencer.
package ysyx_22040237_core_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT_I = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WAIT_D = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] TRAP_NONE  = 2'd0;
  localparam logic [1:0] TRAP_ILL   = 2'd1;
  localparam logic [1:0] TRAP_IF_TO = 2'd2;
  localparam logic [1:0] TRAP_DM_TO = 2'd3;

endpackage

// File: rtl/ysyx_22040237_wait_timer.sv
// Response-wait timer shared by the fetch and data wait states.
// Latency: expired is combinational from the count; the count is registered.
// Backpressure: none; clr dominates en.
module ysyx_22040237_wait_timer #(
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Flags the wait cycle whose increment would reach all-ones, so a valid
  // arriving in that same cycle still beats the trap.
  localparam logic [TO_W-1:0] LAST = ~{{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/ysyx_22040237_core_seq.sv
// Multi-cycle fetch / execute / memory sequencer producing commit strobes.
// Latency: ALU 3 cycles minimum, store 4, load 5; halted/trapped one cycle after the deciding edge.
// Backpressure: FETCH and MEM stall indefinitely on ready; response waits trap on timeout.
module ysyx_22040237_core_seq
  import ysyx_22040237_core_pkg::*;
#(
  parameter int TO_W  = 8,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             if_req,
  input  logic             if_ready,
  input  logic             if_rvalid,
  input  logic [31:0]      if_rdata,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             dec_ld,
  input  logic             dec_st,
  input  logic             dec_ebreak,
  input  logic             dec_invalid,
  output logic             dm_req,
  output logic             dm_we,
  input  logic             dm_ready,
  input  logic             dm_rvalid,
  output logic             pc_we,
  output logic             rd_we,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             trapped,
  output logic [1:0]       trap_cause
);

  state_t     state, state_nxt;
  logic       retire;
  logic [1:0] cause_nxt;
  logic       tmr_clr, tmr_en, tmr_exp;

  always_comb begin
    state_nxt = state;
    pc_we     = 1'b0;
    rd_we     = 1'b0;
    retire    = 1'b0;
    cause_nxt = TRAP_NONE;
    unique case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: if (if_ready) state_nxt = ST_WAIT_I;
      ST_WAIT_I: begin
        if (if_rvalid) begin
          state_nxt = ST_EXEC;
        end else if (tmr_exp) begin
          state_nxt = ST_TRAP;
          cause_nxt = TRAP_IF_TO;
        end
      end
      ST_EXEC: begin
        if (dec_invalid) begin
          state_nxt = ST_TRAP;
          cause_nxt = TRAP_ILL;
        end else if (dec_ebreak) begin
          // ebreak retires but does not move the pc or write a register
          state_nxt = ST_HALT;
          retire    = 1'b1;
        end else if (dec_ld || dec_st) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_FETCH;
          pc_we     = 1'b1;
          rd_we     = 1'b1;
          retire    = 1'b1;
        end
      end
      ST_MEM: begin
        if (dm_ready) begin
          if (dec_st) begin
            state_nxt = ST_FETCH;
            pc_we     = 1'b1;
            retire    = 1'b1;
          end else begin
            state_nxt = ST_WAIT_D;
          end
        end
      end
      ST_WAIT_D: begin
        if (dm_rvalid) begin
          state_nxt = ST_FETCH;
          pc_we     = 1'b1;
          rd_we     = 1'b1;
          retire    = 1'b1;
        end else if (tmr_exp) begin
          state_nxt = ST_TRAP;
          cause_nxt = TRAP_DM_TO;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RST;
      inst       <= '0;
      instret    <= '0;
      trap_cause <= TRAP_NONE;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT_I && if_rvalid) inst <= if_rdata;
      if (retire) instret <= instret + 1'b1;
      if (cause_nxt != TRAP_NONE) trap_cause <= cause_nxt;
    end
  end

  assign tmr_clr = !(state == ST_WAIT_I || state == ST_WAIT_D);
  assign tmr_en  = (state == ST_WAIT_I && !if_rvalid) || (state == ST_WAIT_D && !dm_rvalid);

  ysyx_22040237_wait_timer #(.TO_W(TO_W)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  assign if_req     = (state == ST_FETCH);
  assign dm_req     = (state == ST_MEM);
  // both decode flags high is a store
  assign dm_we      = dm_req && dec_st;
  assign inst_valid = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WAIT_D);
  assign halted     = (state == ST_HALT);
  assign trapped    = (state == ST_TRAP);

endmodule

// File: tb/tb_ysyx_22040237_core_seq.sv
// Randomized and directed scoreboard bench for the core sequencer.
module tb_ysyx_22040237_core_seq;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ILL    = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req, if_ready, if_rvalid;
  logic [31:0] if_rdata, inst;
  logic        inst_valid, dec_ld, dec_st, dec_ebreak, dec_invalid;
  logic        dm_req, dm_we, dm_ready, dm_rvalid, pc_we, rd_we;
  logic [63:0] instret;
  logic        halted, trapped;
  logic [1:0]  trap_cause;

  always #5 clk = ~clk;

  ysyx_22040237_core_seq #(.TO_W(4), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .inst(inst), .inst_valid(inst_valid),
    .dec_ld(dec_ld), .dec_st(dec_st), .dec_ebreak(dec_ebreak), .dec_invalid(dec_invalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_ready(dm_ready), .dm_rvalid(dm_rvalid),
    .pc_we(pc_we), .rd_we(rd_we), .instret(instret),
    .halted(halted), .trapped(trapped), .trap_cause(trap_cause)
  );

  // Toy ISA: bit30 set marks ordinary words, low 3 bits pick ALU(0-3)/load(4)/store(5)/both(6).
  assign dec_ld      = inst[30] && (inst[2:0] == 3'd4 || inst[2:0] == 3'd6);
  assign dec_st      = inst[30] && (inst[2:0] == 3'd5 || inst[2:0] == 3'd6);
  assign dec_ebreak  = (inst == EBREAK);
  assign dec_invalid = (inst == ILL);

  typedef struct {
    logic [31:0] word;
    logic        rd_we;
    logic        st;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prog_q[$];
  int          pulse_q[$];

  int     n_cmp = 0, n_bad = 0;
  int     cyc = 0;
  longint model_cnt = 0;
  int     ifreq_cnt = 0, dmreq_cnt = 0;
  bit     rnd_mode = 0, f_withhold = 0, d_withhold = 0;
  int     f_rdy_cfg, f_rv_cfg, d_rdy_cfg, d_rv_cfg;
  int     f_rdy_cnt, f_cnt, d_rdy_cnt, d_cnt;
  bit     f_pend = 0, d_pend = 0, d_rv_fired = 0;
  logic   d_we_seen = 1'b0;
  int     d_rv_cyc = -1;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int pick(input int c);
    return rnd_mode ? int'($urandom_range(0, 3)) : c;
  endfunction

  function automatic logic [31:0] mk_word(input int k);
    logic [31:0] r;
    r      = $urandom;
    r[31]  = 1'b0;
    r[30]  = 1'b1;
    r[2:0] = 3'(k);
    return r;
  endfunction

  function automatic bit is_store(input logic [31:0] w);
    return (w[2:0] == 3'd5) || (w[2:0] == 3'd6);
  endfunction

  function automatic int pulse_at(input int i);
    return (i < pulse_q.size()) ? pulse_q[i] : -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (cyc != n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_cyc: reached cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic cfg(input bit rnd, input int frdy, input int frv, input int drdy, input int drv);
    rnd_mode  = rnd;
    f_rdy_cfg = frdy; f_rv_cfg = frv; d_rdy_cfg = drdy; d_rv_cfg = drv;
    f_rdy_cnt = frdy; d_rdy_cnt = drdy;
    d_rv_fired = 0;
  endtask

  task automatic check_idle();
    check("rst_if_req", if_req, 0);
    check("rst_dm_req", dm_req, 0);
    check("rst_dm_we", dm_we, 0);
    check("rst_pc_we", pc_we, 0);
    check("rst_rd_we", rd_we, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_instret", instret, 0);
    check("rst_halted", halted, 0);
    check("rst_trapped", trapped, 0);
    check("rst_trap_cause", trap_cause, 0);
  endtask

  // keep_d leaves an outstanding data response in flight across the reset
  task automatic do_reset(input bit keep_d);
    @(negedge clk);
    rst = 1'b1;
    if_ready = 0; if_rvalid = 0; f_pend = 0;
    f_withhold = 0; d_withhold = 0;
    if (!keep_d) begin
      dm_ready = 0; dm_rvalid = 0; d_pend = 0; d_we_seen = 0;
    end
    prog_q.delete();
    exp_q.delete();
    pulse_q.delete();
    model_cnt = 0;
    @(negedge clk);
    check_idle();
    repeat (4) @(negedge clk);
    ifreq_cnt = 0;
    dmreq_cnt = 0;
    rst = 1'b0;
  endtask

  // instruction memory responder
  initial begin
    logic [31:0] w;
    exp_t        e;
    forever begin
      @(posedge clk); #1;
      if (if_ready && !rst) begin
        f_pend = 1;
        f_cnt  = pick(f_rv_cfg);
      end
      if_ready  = 0;
      if_rvalid = 0;
      if (!rst) begin
        if (f_pend) begin
          if (!f_withhold) begin
            if (f_cnt == 0) begin
              w = prog_q.pop_front();
              if_rvalid = 1;
              if_rdata  = w;
              f_pend    = 0;
              if (w == EBREAK) model_cnt++;
              else if (w != ILL) begin
                e.word  = w;
                e.st    = is_store(w);
                e.rd_we = !e.st;
                exp_q.push_back(e);
              end
            end else f_cnt--;
          end
        end else if (if_req && prog_q.size() > 0) begin
          // stray response data while only the request is up must be ignored
          if (rnd_mode) begin
            if_rvalid = 1'($urandom_range(0, 1));
            if_rdata  = $urandom;
          end
          if (f_rdy_cnt == 0) begin
            if_ready  = 1;
            f_rdy_cnt = pick(f_rdy_cfg);
          end else f_rdy_cnt--;
        end
      end
    end
  end

  // data memory responder
  initial begin
    forever begin
      @(posedge clk); #1;
      if (dm_ready && !rst && !d_we_seen) begin
        d_pend = 1;
        d_cnt  = pick(d_rv_cfg);
      end
      dm_ready  = 0;
      dm_rvalid = 0;
      if (d_pend) begin
        if (!d_withhold) begin
          if (d_cnt == 0) begin
            dm_rvalid  = 1;
            d_pend     = 0;
            d_rv_cyc   = cyc;
            d_rv_fired = 1;
          end else d_cnt--;
        end
      end else if (dm_req && !rst) begin
        if (d_rdy_cnt == 0) begin
          dm_ready  = 1;
          d_we_seen = dm_we;
          d_rdy_cnt = pick(d_rdy_cfg);
        end else d_rdy_cnt--;
      end
    end
  end

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_req) ifreq_cnt++;
      if (dm_req) dmreq_cnt++;
      if (rd_we && !pc_we) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_we_alone: rd_we=1 pc_we=0 at cycle %0d", cyc);
      end
      if (dm_req && dm_ready && exp_q.size() > 0) check("dm_we", dm_we, exp_q[0].st);
      if (pc_we) begin
        pulse_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pc_we: pc_we=1 with no retirement pending at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          check("ret_rd_we", rd_we, e.rd_we);
          check("ret_inst", inst, e.word);
          check("ret_instret", instret, model_cnt);
          model_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    if_ready = 0; if_rvalid = 0; if_rdata = 0; dm_ready = 0; dm_rvalid = 0;

    // three ALU instructions on zero-latency memory
    cfg(0, 0, 0, 0, 0);
    do_reset(0);
    check("rst_cycle_if_req", if_req, 0);
    repeat (3) prog_q.push_back(mk_word($urandom_range(0, 3)));
    wait_cyc(12);
    check("alu_pulses", pulse_q.size(), 3);
    check("alu_pulse0", pulse_at(0), 3);
    check("alu_pulse1", pulse_at(1), 6);
    check("alu_pulse2", pulse_at(2), 9);
    check("alu_instret", instret, 3);

    // load: ready after 2 stall cycles, data 3 cycles after acceptance
    cfg(0, 0, 0, 2, 2);
    do_reset(0);
    prog_q.push_back(mk_word(4));
    wait_cyc(12);
    check("ld_pulses", pulse_q.size(), 1);
    check("ld_pulse_cyc", pulse_at(0), 9);
    check("ld_pulse_on_rvalid", pulse_at(0), d_rv_cyc);
    check("ld_dm_req_cycles", dmreq_cnt, 3);
    check("ld_instret", instret, 1);

    // store with both decode flags set, accepted immediately
    cfg(0, 0, 0, 0, 0);
    do_reset(0);
    prog_q.push_back(mk_word(6));
    wait_cyc(4);
    check("st_pc_we", pc_we, 1);
    check("st_rd_we", rd_we, 0);
    wait_cyc(5);
    check("st_back_to_fetch", if_req, 1);
    check("st_no_wait_d", inst_valid, 0);
    check("st_instret", instret, 1);

    // ebreak after one ALU instruction
    cfg(0, 0, 0, 0, 0);
    do_reset(0);
    prog_q.push_back(mk_word(1));
    prog_q.push_back(EBREAK);
    wait_cyc(6);
    check("eb_halted_early", halted, 0);
    wait_cyc(7);
    check("eb_halted", halted, 1);
    check("eb_instret", instret, 2);
    g = ifreq_cnt;
    wait_cyc(27);
    check("eb_no_if_req", ifreq_cnt, g);
    check("eb_instret_frozen", instret, 2);
    check("eb_pulses", pulse_q.size(), 1);

    // illegal instruction
    cfg(0, 0, 0, 0, 0);
    do_reset(0);
    prog_q.push_back(ILL);
    wait_cyc(3);
    check("ill_trapped_early", trapped, 0);
    wait_cyc(4);
    check("ill_trapped", trapped, 1);
    check("ill_cause", trap_cause, 1);
    check("ill_instret", instret, 0);

    // fetch response withheld
    cfg(0, 0, 0, 0, 0);
    do_reset(0);
    f_withhold = 1;
    prog_q.push_back(mk_word(0));
    wait_cyc(16);
    check("ifto_trapped_early", trapped, 0);
    wait_cyc(17);
    check("ifto_trapped", trapped, 1);
    check("ifto_cause", trap_cause, 2);

    // fetch response on the 15th wait cycle still wins
    cfg(0, 0, 14, 0, 0);
    do_reset(0);
    prog_q.push_back(mk_word(2));
    wait_cyc(19);
    check("if15_pulse_cyc", pulse_at(0), 17);
    check("if15_no_trap", trapped, 0);

    // load data withheld
    cfg(0, 0, 0, 0, 0);
    do_reset(0);
    d_withhold = 1;
    prog_q.push_back(mk_word(4));
    wait_cyc(19);
    check("dmto_trapped_early", trapped, 0);
    wait_cyc(20);
    check("dmto_trapped", trapped, 1);
    check("dmto_cause", trap_cause, 3);

    // load data on the 15th wait cycle still wins
    cfg(0, 0, 0, 0, 14);
    do_reset(0);
    prog_q.push_back(mk_word(4));
    wait_cyc(21);
    check("dm15_pulse_cyc", pulse_at(0), 19);
    check("dm15_no_trap", trapped, 0);

    // reset in WAIT_D with the load data arriving while reset is held
    cfg(0, 0, 0, 0, 4);
    do_reset(0);
    prog_q.push_back(mk_word(4));
    wait_cyc(5);
    check("rstwd_in_wait_d", inst_valid, 1);
    do_reset(1);
    check("rstwd_late_rvalid_sent", d_rv_fired, 1);
    wait_cyc(1);
    check("rstwd_fetch_restart", if_req, 1);
    wait_cyc(10);
    check("rstwd_instret", instret, 0);
    check("rstwd_no_pulse", pulse_q.size(), 0);
    check("rstwd_no_trap", trapped, 0);

    // randomized program with random handshake latencies
    cfg(1, 0, 0, 0, 0);
    do_reset(0);
    for (int i = 0; i < 60; i++) prog_q.push_back(mk_word($urandom_range(0, 6)));
    g = 0;
    while ((prog_q.size() > 0 || exp_q.size() > 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("rnd_drained", (prog_q.size() == 0 && exp_q.size() == 0), 1);
    repeat (3) @(negedge clk);
    check("rnd_instret", instret, 60);
    check("rnd_pulses", pulse_q.size(), 60);
    check("rnd_no_trap", trapped, 0);
    check("rnd_no_halt", halted, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_core_seq.md
# ysyx_22040237_core_seq

Multi-cycle sequencer for the ysyx_22040237 RV64 core. It replaces the single-cycle assumption that an instruction word is present every clock. It fetches each instruction from an instruction port with a req/ready/rvalid handshake, latches it into an instruction register, and sequences an optional data-memory access. It then emits one-cycle commit strobes (PC update, register write) to the existing pc_reg and reg_file, halts on ebreak, and traps on invalid instructions or bus timeouts.

## Interface
Reset is synchronous, active-high; one clock.

Parameters:
- TO_W, default 8: timeout counter width; a wait times out after 2^TO_W−1 cycles.
- CNT_W, default 64: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- if_req  out  1  fetch request for the current pc.
- if_ready  in  1  fetch request accepted.
- if_rvalid  in  1  fetch data valid.
- if_rdata  in  32  fetched instruction.
- inst  out  32  instruction register, to the IDU.
- inst_valid  out  1  inst is stable and decode outputs are meaningful.
- dec_ld  in  1  decoded load.
- dec_st  in  1  decoded store.
- dec_ebreak  in  1  decoded ebreak.
- dec_invalid  in  1  decoded illegal instruction.
- dm_req  out  1  data access request.
- dm_we  out  1  data access is a store.
- dm_ready  in  1  data request accepted.
- dm_rvalid  in  1  load data valid.
- pc_we  out  1  pc_reg update strobe.
- rd_we  out  1  reg_file write gate; ANDed externally with the IDU rd_w_en.
- instret  out  CNT_W  count of retired instructions.
- halted  out  1  ebreak reached.
- trapped  out  1  fault stop.
- trap_cause  out  2  fault code: 0 none, 1 invalid instruction, 2 fetch timeout, 3 data timeout.

## Operation
- States:
  - RST: entered on rst.
  - FETCH: if_req=1.
  - WAIT_I: waiting for if_rvalid.
  - EXEC: single cycle; decode is valid.
  - MEM: dm_req=1.
  - WAIT_D: waiting for dm_rvalid.
  - HALT: terminal.
  - TRAP: terminal.
- Transitions:
  - RST → FETCH unconditionally on the first edge after rst is deasserted.
  - FETCH → WAIT_I on an edge where if_req && if_ready.
  - WAIT_I → EXEC on an edge where if_rvalid; inst <= if_rdata on the same edge.
  - EXEC resolves in priority order:
    - dec_invalid → TRAP, cause 1, no commit.
    - dec_ebreak → HALT; instret increments, pc_we=0, rd_we=0.
    - dec_ld or dec_st → MEM.
    - otherwise pc_we=rd_we=1, instret+1, → FETCH.
  - MEM, dm_we=dec_st: on dm_ready, a store commits (pc_we=1, rd_we=0, instret+1) and goes → FETCH; a load goes → WAIT_D.
  - WAIT_D on dm_rvalid: pc_we=rd_we=1, instret+1, → FETCH.
- Timeout counter:
  - Clears on entry to WAIT_I and WAIT_D.
  - Increments each cycle in those states while the awaited valid is low.
  - Reaching all-ones with valid still low → TRAP with cause 2 (WAIT_I) or 3 (WAIT_D).
  - A valid arriving in the same cycle the counter reaches all-ones wins; no trap.
- FETCH and MEM do not time out; a requester may stall indefinitely on ready.
- HALT and TRAP hold until rst. No requests are issued, no strobes fire, and instret is frozen.
- Both dec_ld and dec_st high is treated as a store.
- instret wraps modulo 2^CNT_W.

## Timing
- Reset values:
  - All outputs are 0: inst=0, instret=0, trap_cause=0, state=RST.
  - rst asserted mid-transaction takes effect at that edge.
  - Requests drop in the following cycle; an outstanding if_rvalid/dm_rvalid is ignored.
- Outputs are Moore-decoded from registered state, except pc_we/rd_we:
  - pc_we/rd_we are combinational in EXEC, and in MEM/WAIT_D gated by dm_ready/dm_rvalid.
  - They are high for exactly one cycle per retired instruction.
- Minimum ALU instruction latency is 3 cycles (FETCH, WAIT_I, EXEC) with if_ready and if_rvalid high at the earliest opportunity.
- if_rvalid in the same cycle as if_ready is not accepted; it is sampled only in WAIT_I.
- A load takes at least 5 cycles; a store takes at least 4.
- inst_valid is high in EXEC, MEM and WAIT_D.
- halted/trapped are registered and rise the cycle after the deciding EXEC/WAIT edge.

## Structure
- Package ysyx_22040237_core_pkg holds:
  - the state enum (8 states, 3-bit encoding);
  - trap-cause constants TRAP_NONE, TRAP_ILL, TRAP_IF_TO, TRAP_DM_TO.
- Sub-module ysyx_22040237_wait_timer: TO_W counter with clear/enable inputs and an expired output, instanced once and shared by WAIT_I and WAIT_D.

## Test plan
- Zero-latency memory, three ALU instructions after reset → pc_we pulses at cycles 3, 6, 9 after rst falls; instret=3; rd_we coincident with pc_we.
- Load with dm_ready delayed 2 cycles and dm_rvalid 3 cycles later → exactly one pc_we/rd_we pulse, coincident with dm_rvalid; dm_req held high throughout MEM.
- Store accepted immediately → pc_we=1 and rd_we=0 in the dm_ready cycle; no WAIT_D visit; instret+1.
- ebreak instruction → halted=1 the next cycle; instret counts it; no further if_req over 20 cycles.
- if_rvalid withheld (TO_W=4) → trapped=1, trap_cause=2 after 15 wait cycles. Repeat with dm_rvalid withheld → trap_cause=3. Repeat with rvalid arriving on cycle 15 → no trap.
- Assert rst during WAIT_D, then a late dm_rvalid → all outputs 0 after the reset edge; the late rvalid is ignored; FETCH restarts one cycle after rst falls.
